// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op classes, funct codes and
// the EX/MEM occupancy state.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MUL   = 2'd1,
        FULL  = 2'd2
    } ex_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W
// cycles per product, low DATA_W bits only.
module mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [DATA_W-1:0] w_acc_next;

    // The last iteration's sum is handed out directly so the result lands in
    // the EX/MEM register on the same edge that ends the multiply.
    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);
    assign busy       = r_busy;
    assign done       = r_busy && (r_cnt == CNT_W'(DATA_W - 1));
    assign product    = w_acc_next;

    // Operand load on start, then one shift-add step per cycle until done.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every register
        // samples pre-edge values; blocking here would chain the updates.
        if (rst || abort) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_a    <= r_a << 1;
            r_b    <= r_b >> 1;
            r_acc  <= w_acc_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage_mc.sv
// Registered execute stage: single-cycle ALU, iterative multiply, and an
// EX/MEM output register with valid/ready backpressure and branch flush.
module ex_stage_mc
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              regdst,
    input  logic              alusrc,
    input  logic [1:0]        aluop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] dst_addr,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] branch_target,
    output logic              zero,
    output logic              busy
);

    ex_state_e         r_state;
    ex_state_e         w_state_next;
    logic [REG_AW-1:0] r_dst_addr;
    logic [DATA_W-1:0] r_alu_result;
    logic [DATA_W-1:0] r_branch_target;

    logic [DATA_W-1:0] w_operand_b;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_is_mul;
    logic              w_accept;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;

    assign w_operand_b = alusrc ? imm : rt_data;
    assign w_is_mul    = (aluop == ALUOP_FUNCT) && (imm[5:0] == FUNCT_MUL);
    assign in_ready    = !flush && ((r_state == EMPTY) || ((r_state == FULL) && out_ready));
    assign w_accept    = in_valid && in_ready;

    // Single-cycle ALU; the multiply path bypasses this result.
    always_comb begin
        // NOTE: the default assignment first keeps this block purely
        // combinational; a path that skipped it would infer a latch.
        w_alu_result = '0;
        case (aluop)
            ALUOP_ADD:   w_alu_result = rs_data + w_operand_b;
            ALUOP_SUB:   w_alu_result = rs_data - w_operand_b;
            ALUOP_FUNCT: begin
                case (imm[5:0])
                    FUNCT_ADD: w_alu_result = rs_data + w_operand_b;
                    FUNCT_SUB: w_alu_result = rs_data - w_operand_b;
                    FUNCT_AND: w_alu_result = rs_data & w_operand_b;
                    FUNCT_OR:  w_alu_result = rs_data | w_operand_b;
                    FUNCT_SLT: w_alu_result = {{(DATA_W-1){1'b0}},
                                               ($signed(rs_data) < $signed(w_operand_b))};
                    default:   w_alu_result = '0;
                endcase
            end
            default:     w_alu_result = '0;
        endcase
    end

    mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul_iter (
        .clk     (clk),
        .rst     (rst),
        .abort   (flush),
        .start   (w_accept && w_is_mul),
        .a       (rs_data),
        .b       (w_operand_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    // Next-state: flush wins over drain and accept.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) w_state_next = w_is_mul ? MUL : FULL;
                end
                MUL: begin
                    if (w_mul_done) w_state_next = FULL;
                end
                FULL: begin
                    if (out_ready) begin
                        if (w_accept) w_state_next = w_is_mul ? MUL : FULL;
                        else          w_state_next = EMPTY;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_next;
    end

    // EX/MEM payload: destination and branch target latch at accept, the
    // result at accept (single-cycle) or at multiply completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dst_addr      <= '0;
            r_alu_result    <= '0;
            r_branch_target <= '0;
        end else if (w_accept) begin
            r_dst_addr      <= regdst ? rd_addr : rt_addr;
            r_branch_target <= pc_plus4 + (imm << 2);
            if (!w_is_mul) r_alu_result <= w_alu_result;
        end else if (w_mul_done && !flush) begin
            r_alu_result <= w_mul_product;
        end
    end

    assign out_valid     = (r_state == FULL);
    assign busy          = w_mul_busy;
    assign dst_addr      = r_dst_addr;
    assign alu_result    = r_alu_result;
    assign branch_target = r_branch_target;
    assign zero          = (r_alu_result == '0);

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ex_stage_mc;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready, regdst, alusrc;
    logic [DW-1:0] pc_plus4, imm, rs_data, rt_data;
    logic [AW-1:0] rt_addr, rd_addr;
    logic [1:0]    aluop;
    logic          in_ready, out_valid, zero, busy;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] alu_result, branch_target;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage_mc #(.DATA_W(DW), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .pc_plus4(pc_plus4), .imm(imm), .rs_data(rs_data), .rt_data(rt_data),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .regdst(regdst), .alusrc(alusrc),
        .aluop(aluop), .out_valid(out_valid), .out_ready(out_ready), .dst_addr(dst_addr),
        .alu_result(alu_result), .branch_target(branch_target), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU straight from the op table.
    function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [63:0] p;
        case (op)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: begin
                case (f)
                    6'h20: return a + b;
                    6'h22: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h2A: return ($signed(a) < $signed(b)) ? 1 : 0;
                    6'h18: begin p = {32'b0, a} * {32'b0, b}; return p[DW-1:0]; end
                    default: return 0;
                endcase
            end
            default: return 0;
        endcase
    endfunction

    // Transaction model: is a result held, how many cycles until visible, and its payload.
    bit            m_has  = 0;
    int            m_wait = 0;
    logic [DW-1:0] m_res, m_bt;
    logic [AW-1:0] m_dst;

    // Compare process: check outputs mid-cycle, then advance the model across the coming edge.
    always @(negedge clk) begin
        bit exp_ready, acc, mul;
        logic [DW-1:0] b;
        if (rst) begin
            m_has = 0;
            m_wait = 0;
        end else begin
            exp_ready = !flush && (!m_has || (m_wait == 0 && out_ready));
            check("in_ready", in_ready, exp_ready);
            check("out_valid", out_valid, m_has && m_wait == 0);
            check("busy", busy, m_has && m_wait > 0);
            if (m_has && m_wait == 0) begin
                check("alu_result", alu_result, m_res);
                check("dst_addr", dst_addr, m_dst);
                check("branch_target", branch_target, m_bt);
                check("zero", zero, m_res == 0);
            end
            acc = in_valid && exp_ready;
            if (flush) begin
                m_has = 0;
                m_wait = 0;
            end else if (acc) begin
                b      = alusrc ? imm : rt_data;
                mul    = (aluop == 2'b10) && (imm[5:0] == 6'h18);
                m_has  = 1;
                m_wait = mul ? DW : 0;
                m_res  = ref_alu(aluop, imm[5:0], rs_data, b);
                m_dst  = regdst ? rd_addr : rt_addr;
                m_bt   = pc_plus4 + (imm * 4);
            end else if (m_has && m_wait > 0) begin
                m_wait--;
            end else if (m_has && out_ready) begin
                m_has = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [DW-1:0] im, input logic [DW-1:0] rs,
                          input logic [DW-1:0] rt, input logic src, input logic rdst,
                          input logic [AW-1:0] rta, input logic [AW-1:0] rda, input logic [DW-1:0] pc);
        aluop = op; imm = im; rs_data = rs; rt_data = rt; alusrc = src; regdst = rdst;
        rt_addr = rta; rd_addr = rda; pc_plus4 = pc;
    endtask

    initial begin
        int n;
        bit stuck;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        set_op(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        rst = 0;

        // Reset state and first add.
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_zero", zero, 1);
        check("rst_result", alu_result, 0);
        set_op(2'b10, 32'h20, 5, 7, 0, 1, 9, 3, 32'h100);
        in_valid = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        check("add_result", alu_result, 12);
        check("add_dst", dst_addr, 3);
        check("add_bt", branch_target, 32'h180);
        check("add_zero", zero, 0);
        out_ready = 1;
        step();

        // Four back-to-back ops, then hold under backpressure.
        for (int i = 0; i < 4; i++) begin
            set_op(2'b00, 0, i + 1, 10, 0, 0, 5'(i), 0, 0);
            in_valid = 1;
            step();
            @(negedge clk);
            check("stream_valid", out_valid, 1);
            check("stream_result", alu_result, i + 11);
        end
        out_ready = 0;
        set_op(2'b00, 0, 100, 100, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            check("hold_result", alu_result, 14);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        step();

        // Multiply 0xFFFFFFFF x 3; inputs scrambled during the multiply.
        out_ready = 0;
        set_op(2'b10, 32'h18, 32'hFFFF_FFFF, 3, 0, 1, 0, 7, 0);
        in_valid = 1;
        step();
        set_op(2'b00, 0, 1, 1, 0, 0, 2, 2, 0);
        @(negedge clk);
        n = 0; stuck = 0;
        while (busy === 1'b1 && n < 40) begin
            if (in_ready !== 1'b0) stuck = 1;
            n++;
            step();
            @(negedge clk);
        end
        check("mul_busy_cycles", n, 32);
        check("mul_in_ready_low", stuck, 0);
        check("mul_valid", out_valid, 1);
        check("mul_result", alu_result, 32'hFFFF_FFFD);
        check("mul_dst", dst_addr, 7);
        in_valid = 0; out_ready = 1;
        step();

        // Flush in cycle 10 of a multiply.
        set_op(2'b10, 32'h18, 32'h1234, 32'h55, 0, 0, 4, 0, 0);
        in_valid = 1;
        step();
        in_valid = 0;
        repeat (9) step();
        flush = 1;
        step();
        flush = 0;
        @(negedge clk);
        check("flush_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_in_ready", in_ready, 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            @(negedge clk);
            if (out_valid === 1'b1) n++;
        end
        check("flush_never_presented", n, 0);
        set_op(2'b00, 0, 20, 22, 0, 0, 6, 0, 0);
        in_valid = 1;
        step();
        in_valid = 0;
        @(negedge clk);
        check("post_flush_add", alu_result, 42);

        // slt, sub to zero, unknown funct, reserved aluop.
        set_op(2'b10, 32'h2A, 32'h8000_0000, 1, 0, 0, 1, 0, 0);
        in_valid = 1;
        step();
        @(negedge clk);
        check("slt_result", alu_result, 1);
        check("slt_zero", zero, 0);
        set_op(2'b01, 0, 9, 9, 0, 0, 1, 0, 0);
        step();
        @(negedge clk);
        check("sub_result", alu_result, 0);
        check("sub_zero", zero, 1);
        set_op(2'b10, 32'h3F, 77, 5, 0, 0, 1, 0, 0);
        step();
        @(negedge clk);
        check("funct3f_result", alu_result, 0);
        set_op(2'b11, 0, 77, 5, 0, 0, 1, 0, 0);
        step();
        @(negedge clk);
        check("rsvd_result", alu_result, 0);
        in_valid = 0;
        step();

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [5:0] fsel [7];
            fsel = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'($urandom)};
            rst       = ($urandom_range(0, 299) == 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            imm       = $urandom;
            imm[5:0]  = fsel[$urandom_range(0, 6)];
            set_op(2'($urandom), imm, ($urandom_range(0, 3) == 0) ? rt_data : $urandom,
                   ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                   1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), $urandom);
            step();
        end
        rst = 0; flush = 0; in_valid = 0; out_ready = 1;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
